// File: rtl/tx_packet_parser_pkg.sv
// Shared constants, header layout and state encoding for the TX packet parser.
package tx_packet_parser_pkg;

   localparam int          PKT_WORDS         = 256;
   localparam int          HDR_WORDS         = 4;
   localparam int          MAX_PAYLOAD_BYTES = 504;
   localparam int          MAX_PAYLOAD_WORDS = MAX_PAYLOAD_BYTES / 2;
   localparam logic [31:0] IMMEDIATE_TS      = 32'hFFFF_FFFF;

   // Header word 0 / word 1 bit positions
   localparam int W0_TAG_MSB   = 15;
   localparam int W0_TAG_LSB   = 9;
   localparam int W0_LEN_MSB   = 8;
   localparam int W0_LEN_LSB   = 0;
   localparam int W1_OVERRUN   = 15;
   localparam int W1_UNDERRUN  = 14;
   localparam int W1_START     = 13;
   localparam int W1_END       = 12;
   localparam int W1_CHAN_MSB  = 4;
   localparam int W1_CHAN_LSB  = 0;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_HDR       = 3'd1,
      ST_WAIT_TIME = 3'd2,
      ST_PAYLOAD   = 3'd3,
      ST_DISCARD   = 3'd4
   } tx_state_e;

   function automatic logic len_clamped(input logic [8:0] len_bytes);
      return (len_bytes > 9'(MAX_PAYLOAD_BYTES));
   endfunction

   // Payload words to forward: bytes rounded up to whole words, capped.
   function automatic logic [7:0] payload_words(input logic [8:0] len_bytes);
      if (len_clamped(len_bytes)) begin
         return 8'(MAX_PAYLOAD_WORDS);
      end else begin
         return 8'((len_bytes + 9'd1) >> 1);
      end
   endfunction

endpackage

// File: rtl/tx_ts_compare.sv
// Signed wrap-aware comparison of a packet timestamp against the running sample clock.
module tx_ts_compare
   import tx_packet_parser_pkg::*;
(
   input  logic [31:0] ts,
   input  logic [31:0] cur_time,
   output logic        late,
   output logic        now,
   output logic        future
);

   logic signed [31:0] diff_s;

   // Difference taken modulo 2^32 so the counter may wrap between header and send time.
   always_comb begin
      diff_s = signed'(ts - cur_time);
      late   = (diff_s < 32'sd0);
      now    = (diff_s == 32'sd0);
      future = !late && !now;
   end

endmodule

// File: rtl/tx_packet_parser.sv
// Reads 256-word packets from the upstream USB FIFO, honours the header timestamp
// and forwards the payload to one destination FIFO; always consumes exactly 256 words.
module tx_packet_parser
   import tx_packet_parser_pkg::*;
#(
   parameter int         NUM_CHAN = 2,
   parameter logic [4:0] CMD_CHAN = 5'h1F
) (
   input  logic                txclk,
   input  logic                reset,
   input  logic [15:0]         usbdata,
   input  logic                have_pkt_rdy,
   output logic                rdreq,
   input  logic [31:0]         timestamp_clock,
   input  logic [NUM_CHAN:0]   dst_almost_full,
   output logic [15:0]         wr_data,
   output logic [NUM_CHAN:0]   wr_en,
   input  logic                clear_status,
   output logic                late_drop,
   output logic                bad_pkt,
   output logic                busy,
   output logic [15:0]         debugbus
);

   localparam logic [NUM_CHAN:0] EN_ONE = {{NUM_CHAN{1'b0}}, 1'b1};

   tx_state_e         state_r;
   logic [8:0]        req_cnt_r;
   logic [7:0]        pay_req_r;
   logic [7:0]        pay_words_r;
   logic [2:0]        hdr_cnt_r;
   logic [8:0]        len_r;
   logic [4:0]        chan_r;
   logic [31:0]       ts_r;
   logic [NUM_CHAN:0] dest_mask_r;
   logic              rdreq_r;
   logic              rd_vld_r;
   logic [NUM_CHAN:0] wr_en_r;
   logic [15:0]       wr_data_r;
   logic              late_drop_r;
   logic              bad_pkt_r;
   logic              busy_r;

   logic              chan_ok_s;
   logic [NUM_CHAN:0] chan_mask_s;
   logic              ts_late_s;
   logic              ts_now_s;
   logic              ts_future_s;
   logic              pipe_idle_s;
   logic              dest_af_s;
   logic              pay_more_s;

   tx_ts_compare u_ts_compare (
      .ts       (ts_r),
      .cur_time (timestamp_clock),
      .late     (ts_late_s),
      .now      (ts_now_s),
      .future   (ts_future_s)
   );

   // Destination decode: data channels map directly, the command channel sits above them.
   always_comb begin
      chan_ok_s   = 1'b0;
      chan_mask_s = '0;
      if (chan_r == CMD_CHAN) begin
         chan_ok_s   = 1'b1;
         chan_mask_s = EN_ONE << NUM_CHAN;
      end else if (chan_r < 5'(NUM_CHAN)) begin
         chan_ok_s   = 1'b1;
         chan_mask_s = EN_ONE << chan_r;
      end else begin
         chan_ok_s   = 1'b0;
         chan_mask_s = '0;
      end
   end

   // One payload word in flight at a time keeps the 1-word almost-full margin safe.
   always_comb begin
      pipe_idle_s = !rdreq_r && !rd_vld_r && !(|wr_en_r);
      dest_af_s   = |(dst_almost_full & dest_mask_r);
      pay_more_s  = (pay_req_r < pay_words_r);
   end

   // Packet FSM with registered read strobe, write path and sticky status.
   always_ff @(posedge txclk or posedge reset) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         req_cnt_r   <= 9'd0;
         pay_req_r   <= 8'd0;
         pay_words_r <= 8'd0;
         hdr_cnt_r   <= 3'd0;
         len_r       <= 9'd0;
         chan_r      <= 5'd0;
         ts_r        <= 32'd0;
         dest_mask_r <= '0;
         rdreq_r     <= 1'b0;
         rd_vld_r    <= 1'b0;
         wr_en_r     <= '0;
         wr_data_r   <= 16'd0;
         late_drop_r <= 1'b0;
         bad_pkt_r   <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         rd_vld_r <= rdreq_r;
         wr_en_r  <= '0;
         // Clear first so a set later in this block takes priority.
         if (clear_status) begin
            late_drop_r <= 1'b0;
            bad_pkt_r   <= 1'b0;
         end
         if (rd_vld_r && (state_r == ST_PAYLOAD)) begin
            wr_en_r   <= dest_mask_r;
            wr_data_r <= usbdata;
         end
         case (state_r)
            ST_IDLE: begin
               rdreq_r <= 1'b0;
               if (have_pkt_rdy) begin
                  state_r   <= ST_HDR;
                  busy_r    <= 1'b1;
                  rdreq_r   <= 1'b1;
                  req_cnt_r <= 9'd1;
                  hdr_cnt_r <= 3'd0;
                  pay_req_r <= 8'd0;
               end
            end
            ST_HDR: begin
               if (rd_vld_r) begin
                  hdr_cnt_r <= hdr_cnt_r + 3'd1;
                  case (hdr_cnt_r)
                     3'd0:    len_r        <= usbdata[W0_LEN_MSB:W0_LEN_LSB];
                     3'd1:    chan_r       <= usbdata[W1_CHAN_MSB:W1_CHAN_LSB];
                     3'd2:    ts_r[15:0]   <= usbdata;
                     3'd3:    ts_r[31:16]  <= usbdata;
                     default: ts_r         <= ts_r;
                  endcase
               end
               if (req_cnt_r < 9'(HDR_WORDS)) begin
                  rdreq_r   <= 1'b1;
                  req_cnt_r <= req_cnt_r + 9'd1;
               end else begin
                  rdreq_r <= 1'b0;
               end
               if (hdr_cnt_r == 3'(HDR_WORDS)) begin
                  pay_words_r <= payload_words(len_r);
                  dest_mask_r <= chan_mask_s;
                  if (len_clamped(len_r)) begin
                     bad_pkt_r <= 1'b1;
                  end
                  if (!chan_ok_s) begin
                     bad_pkt_r <= 1'b1;
                     state_r   <= ST_DISCARD;
                  end else if (ts_r == IMMEDIATE_TS) begin
                     state_r <= ST_PAYLOAD;
                  end else if (ts_late_s) begin
                     late_drop_r <= 1'b1;
                     state_r     <= ST_DISCARD;
                  end else if (ts_future_s) begin
                     state_r <= ST_WAIT_TIME;
                  end else begin
                     state_r <= ST_PAYLOAD;
                  end
               end
            end
            ST_WAIT_TIME: begin
               rdreq_r <= 1'b0;
               if (ts_now_s) begin
                  state_r <= ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               if (pay_more_s && pipe_idle_s && !dest_af_s) begin
                  rdreq_r   <= 1'b1;
                  req_cnt_r <= req_cnt_r + 9'd1;
                  pay_req_r <= pay_req_r + 8'd1;
               end else begin
                  rdreq_r <= 1'b0;
                  if (!pay_more_s && pipe_idle_s) begin
                     state_r <= ST_DISCARD;
                  end
               end
            end
            ST_DISCARD: begin
               if (req_cnt_r < 9'(PKT_WORDS)) begin
                  rdreq_r   <= 1'b1;
                  req_cnt_r <= req_cnt_r + 9'd1;
               end else begin
                  rdreq_r <= 1'b0;
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            default: begin
               rdreq_r <= 1'b0;
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign rdreq     = rdreq_r;
   assign wr_en     = wr_en_r;
   assign wr_data   = wr_data_r;
   assign late_drop = late_drop_r;
   assign bad_pkt   = bad_pkt_r;
   assign busy      = busy_r;
   assign debugbus  = {state_r, req_cnt_r[7:0], chan_r};

endmodule

// File: tb/tb_tx_packet_parser.sv
// Scoreboard bench: upstream FIFO model feeds packets, expected writes are queued at send time.
module tb_tx_packet_parser;
   import tx_packet_parser_pkg::*;

   localparam int NUM_CHAN = 2;

   logic              txclk = 1'b0;
   logic              reset;
   logic [15:0]       usbdata;
   logic              have_pkt_rdy;
   logic              rdreq;
   logic [31:0]       timestamp_clock = 32'h0000_F000;
   logic [NUM_CHAN:0] dst_almost_full;
   logic [15:0]       wr_data;
   logic [NUM_CHAN:0] wr_en;
   logic              clear_status;
   logic              late_drop;
   logic              bad_pkt;
   logic              busy;
   logic [15:0]       debugbus;

   int          total;
   int          bad;
   logic [15:0] usb_q[$];
   logic [18:0] exp_q[$];
   logic [15:0] pend_word;
   bit          pend;
   int          tot_rdreq, tot_wr, base_rdreq, base_wr, viol, af_cnt;
   logic [31:0] first_pay_tc;
   bit          clr_in_hdr, clr_req, af_toggle;

   tx_packet_parser #(.NUM_CHAN(NUM_CHAN), .CMD_CHAN(5'h1F)) dut (
      .txclk           (txclk),
      .reset           (reset),
      .usbdata         (usbdata),
      .have_pkt_rdy    (have_pkt_rdy),
      .rdreq           (rdreq),
      .timestamp_clock (timestamp_clock),
      .dst_almost_full (dst_almost_full),
      .wr_data         (wr_data),
      .wr_en           (wr_en),
      .clear_status    (clear_status),
      .late_drop       (late_drop),
      .bad_pkt         (bad_pkt),
      .busy            (busy),
      .debugbus        (debugbus)
   );

   always #5 txclk = ~txclk;

   always @(posedge txclk) timestamp_clock <= timestamp_clock + 32'd1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One negedge step: FIFO model, scoreboard, and input drivers.
   task automatic tick();
      logic [18:0] e;
      @(negedge txclk);
      if (pend) usbdata = pend_word;
      pend = 1'b0;
      if (rdreq) begin
         tot_rdreq++;
         if (usb_q.size() > 0) begin
            pend_word = usb_q.pop_front();
            pend      = 1'b1;
         end
         if (tot_rdreq - base_rdreq == 5) first_pay_tc = timestamp_clock;
         if (debugbus[15:13] == ST_IDLE || debugbus[15:13] == ST_WAIT_TIME) viol++;
      end
      have_pkt_rdy = (usb_q.size() >= 256);
      if (wr_en != 3'b000) begin
         tot_wr++;
         if (exp_q.size() == 0) begin
            chk("wr_unexpected", {29'd0, wr_en}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("wr_dest", {29'd0, wr_en}, {29'd0, e[18:16]});
            chk("wr_data", {16'd0, wr_data}, {16'd0, e[15:0]});
         end
      end
      clear_status = clr_in_hdr ? (debugbus[15:13] == ST_HDR) : clr_req;
      if (af_toggle) begin
         af_cnt++;
         if (af_cnt == 3) begin
            af_cnt = 0;
            dst_almost_full[0] = ~dst_almost_full[0];
         end
      end
   endtask

   task automatic send_pkt(input logic [8:0] len, input logic [4:0] chan, input logic [31:0] ts,
                           input logic [2:0] mask, input bit exp_wr);
      logic [15:0] w[256];
      int n;
      w[0] = {7'h2A, len};
      w[1] = {4'b0011, 7'd0, chan};
      w[2] = ts[15:0];
      w[3] = ts[31:16];
      for (int i = 4; i < 256; i++) w[i] = 16'($urandom);
      n = (len > 9'd504) ? 252 : (int'(len) + 1) / 2;
      if (exp_wr) for (int i = 0; i < n; i++) exp_q.push_back({mask, w[4 + i]});
      base_rdreq = tot_rdreq;
      base_wr    = tot_wr;
      for (int i = 0; i < 256; i++) usb_q.push_back(w[i]);
   endtask

   task automatic wait_pkt(input string tag, input int exp_writes);
      bit done = 1'b0;
      for (int i = 0; i < 4000 && !done; i++) begin
         tick();
         if ((tot_rdreq - base_rdreq) == 256 && !busy) done = 1'b1;
      end
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_rdreq"}, tot_rdreq - base_rdreq, 32'd256);
      chk({tag, "_writes"}, tot_wr - base_wr, exp_writes);
      chk({tag, "_sb_empty"}, exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   task automatic pulse_clear();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      tick();
   endtask

   initial begin
      logic [31:0] ts;
      bit reached;
      total = 0; bad = 0; tot_rdreq = 0; tot_wr = 0; base_rdreq = 0; base_wr = 0;
      viol = 0; af_cnt = 0; pend = 1'b0; pend_word = 16'd0; first_pay_tc = 32'd0;
      clr_in_hdr = 1'b0; clr_req = 1'b0; af_toggle = 1'b0;
      reset = 1'b1; usbdata = 16'd0; have_pkt_rdy = 1'b0;
      dst_almost_full = 3'b000; clear_status = 1'b0;
      repeat (3) tick();
      chk("rst_rdreq", {31'd0, rdreq}, 32'd0);
      chk("rst_wr_en", {29'd0, wr_en}, 32'd0);
      chk("rst_wr_data", {16'd0, wr_data}, 32'd0);
      chk("rst_flags", {30'd0, late_drop, bad_pkt}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_debug", {16'd0, debugbus}, 32'd0);
      reset = 1'b0;
      repeat (2) tick();

      send_pkt(9'd504, 5'd0, IMMEDIATE_TS, 3'b001, 1'b1);
      wait_pkt("imm504", 252);

      ts = timestamp_clock + 32'd100;
      send_pkt(9'd9, 5'd1, ts, 3'b010, 1'b1);
      wait_pkt("future", 5);
      chk("wait_not_early", {31'd0, first_pay_tc > ts}, 32'd1);
      chk("wait_latency", {31'd0, first_pay_tc <= ts + 32'd4}, 32'd1);

      clr_in_hdr = 1'b1;
      send_pkt(9'd40, 5'd0, timestamp_clock - 32'd1, 3'b001, 1'b0);
      wait_pkt("late", 0);
      clr_in_hdr = 1'b0;
      chk("late_set_wins", {31'd0, late_drop}, 32'd1);
      chk("late_no_bad", {31'd0, bad_pkt}, 32'd0);
      pulse_clear();
      chk("late_cleared", {31'd0, late_drop}, 32'd0);

      send_pkt(9'd16, 5'd7, IMMEDIATE_TS, 3'b000, 1'b0);
      wait_pkt("badchan", 0);
      chk("badchan_flag", {31'd0, bad_pkt}, 32'd1);
      chk("badchan_no_late", {31'd0, late_drop}, 32'd0);
      pulse_clear();
      chk("bad_cleared", {31'd0, bad_pkt}, 32'd0);

      send_pkt(9'd20, 5'h1F, IMMEDIATE_TS, 3'b100, 1'b1);
      wait_pkt("cmdchan", 10);
      chk("cmd_no_bad", {31'd0, bad_pkt}, 32'd0);

      send_pkt(9'd0, 5'd0, IMMEDIATE_TS, 3'b001, 1'b1);
      wait_pkt("zerolen", 0);

      send_pkt(9'd511, 5'd1, IMMEDIATE_TS, 3'b010, 1'b1);
      wait_pkt("clamp", 252);
      chk("clamp_bad", {31'd0, bad_pkt}, 32'd1);
      pulse_clear();

      af_toggle = 1'b1;
      send_pkt(9'd504, 5'd0, IMMEDIATE_TS, 3'b001, 1'b1);
      wait_pkt("af_toggle", 252);
      af_toggle = 1'b0;
      dst_almost_full = 3'b000;

      send_pkt(9'd504, 5'd0, IMMEDIATE_TS, 3'b001, 1'b1);
      reached = 1'b0;
      for (int i = 0; i < 2000 && !reached; i++) begin
         tick();
         if ((tot_wr - base_wr) >= 100) reached = 1'b1;
      end
      chk("midrst_reached", {31'd0, reached}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("midrst_wr_en", {29'd0, wr_en}, 32'd0);
      chk("midrst_rdreq", {31'd0, rdreq}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_state", {29'd0, debugbus[15:13]}, 32'd0);
      usb_q.delete();
      exp_q.delete();
      pend = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      repeat (2) tick();
      chk("midrst_quiet", tot_wr - base_wr, 32'd100);

      send_pkt(9'd30, 5'd1, IMMEDIATE_TS, 3'b010, 1'b1);
      wait_pkt("after_rst", 15);

      chk("rdreq_idle_wait", viol, 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
